b06_irq_source: RTL and testbench

- Request-side counterpart of the b06 interrupt handler FSM.
- Queues local interrupt events and presents them to the handler on eql/cont_eql, one at a time.
- Tracks the handler's ackout handshake with a timeout, and reports served and error status to the local controller.
- Instantiated beside the handler; eql/cont_eql drive the handler's inputs of the same names, and ackout returns from it.

---
 rtl/b06_irq_source.sv | 123 ++++++++++++
 tb/tb_b06_irq_source.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b06_irq_source.sv
// Request side of the b06 interrupt handshake: queues local events and presents them one at a
// time on eql/cont_eql, tracking ackout with a timeout and reporting served/error status.
module b06_irq_source #(
    parameter int unsigned MAX_PEND = 7,
    parameter int unsigned PW       = 3,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned TW       = 4,
    parameter int unsigned SW       = 8
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          irq_req_i,
    input  logic          clr_err_i,
    input  logic          ackout_i,
    output logic          eql_o,
    output logic          cont_eql_o,
    output logic          busy_o,
    output logic [PW-1:0] pend_cnt_o,
    output logic [SW-1:0] served_cnt_o,
    output logic          ovf_err_o,
    output logic          tmo_err_o
);

    typedef enum logic [1:0] {StIdle, StAssert, StHold, StRelease} state_e;

    localparam logic [PW-1:0] PendMax = PW'(MAX_PEND);
    localparam logic [PW-1:0] PendOne = PW'(1);
    // Timer counts completed assertion cycles; the last one aborts the request.
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pend_q, pend_d;
    logic [SW-1:0] served_q, served_d;
    logic          eql_q, eql_d;
    logic          cont_q, cont_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;
    logic          ack_take, tmo_hit, ovf_set;

    always_comb begin
        ack_take = (state_q == StAssert) && ackout_i;
        tmo_hit  = (state_q == StAssert) && !ackout_i && (timer_q == TmoLast);
        state_d  = state_q;
        timer_d  = timer_q;

        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (pend_q != '0) state_d = StAssert;
            end
            StAssert: begin
                timer_d = timer_q + TW'(1);
                if (ackout_i)     state_d = StHold;
                else if (tmo_hit) state_d = StRelease;
            end
            StHold: begin
                if (!ackout_i) state_d = StRelease;
            end
            StRelease: begin
                timer_d = '0;
                if (!ackout_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // An ack and a new request on the same edge cancel out, even when saturated.
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (ack_take && !irq_req_i) begin
            pend_d = pend_q - PendOne;
        end else if (!ack_take && irq_req_i) begin
            if (pend_q == PendMax) ovf_set = 1'b1;
            else                   pend_d  = pend_q + PendOne;
        end

        served_d = ack_take ? served_q + SW'(1) : served_q;
        ovf_d    = ovf_set | (ovf_q & !clr_err_i);
        tmo_d    = tmo_hit | (tmo_q & !clr_err_i);

        eql_d  = (state_d == StAssert) || (state_d == StHold);
        busy_d = (state_d != StIdle);
        case (state_d)
            StAssert: cont_d = (pend_d > PendOne);
            StHold:   cont_d = cont_q;
            default:  cont_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            pend_q   <= '0;
            served_q <= '0;
            eql_q    <= 1'b0;
            cont_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            served_q <= served_d;
            eql_q    <= eql_d;
            cont_q   <= cont_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    assign eql_o        = eql_q;
    assign cont_eql_o   = cont_q;
    assign busy_o       = busy_q;
    assign pend_cnt_o   = pend_q;
    assign served_cnt_o = served_q;
    assign ovf_err_o    = ovf_q;
    assign tmo_err_o    = tmo_q;

endmodule

// File: tb/tb_b06_irq_source.sv
// Directed bench for b06_irq_source; cycle k is the interval following rising edge k.
module tb_b06_irq_source;

    logic       clk = 1'b0;
    logic       rst_n, irq, clr, ack;
    logic       eql, cont, busy, ovf, tmo;
    logic [2:0] pend;
    logic [7:0] served;

    int total = 0;
    int bad = 0;

    b06_irq_source dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .irq_req_i   (irq),
        .clr_err_i   (clr),
        .ackout_i    (ack),
        .eql_o       (eql),
        .cont_eql_o  (cont),
        .busy_o      (busy),
        .pend_cnt_o  (pend),
        .served_cnt_o(served),
        .ovf_err_o   (ovf),
        .tmo_err_o   (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until eql reaches level; n is the number of ticks taken.
    task automatic wait_eql(input logic level, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 60) begin
            tick();
            n++;
            if (eql === level) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq = 1'b0; clr = 1'b0; ack = 1'b0;
        tick(); tick();
        total++;
        if ({eql, cont, busy, ovf, tmo, pend, served} !== 16'h0) begin
            $display("FAIL reset_outputs got=%h exp=0000", {eql, cont, busy, ovf, tmo, pend, served});
            bad++;
        end
        rst_n = 1'b1;
        tick(); tick();
        total++;
        if ({eql, busy} !== 2'b00) begin
            $display("FAIL reset_idle got=%b exp=00", {eql, busy});
            bad++;
        end
    endtask

    task automatic test_single();
        irq = 1'b1; tick(); irq = 1'b0;               // c1
        total++;
        if ({pend, eql} !== {3'd1, 1'b0}) begin
            $display("FAIL single_c1 got=%h exp=2", {pend, eql});
            bad++;
        end
        tick();                                       // c2
        total++;
        if ({eql, cont, busy} !== 3'b101) begin
            $display("FAIL single_eql got=%b exp=101", {eql, cont, busy});
            bad++;
        end
        tick(); tick(); ack = 1'b1;                   // c4
        tick();                                       // c5
        total++;
        if ({served, pend} !== {8'd1, 3'd0}) begin
            $display("FAIL single_ack got=%0d/%0d exp=1/0", served, pend);
            bad++;
        end
        tick(); ack = 1'b0;                           // c6
        tick();                                       // c7
        total++;
        if (eql !== 1'b0) begin
            $display("FAIL single_release got=%b exp=0", eql);
            bad++;
        end
        tick();                                       // c8
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL single_idle got=%b exp=0", busy);
            bad++;
        end
    endtask

    task automatic test_burst();
        logic exp_cont [3];
        int   n;
        bit   ok;
        exp_cont[0] = 1'b1; exp_cont[1] = 1'b1; exp_cont[2] = 1'b0;
        irq = 1'b1; tick(); tick();                   // c2, third pulse still driven
        total++;
        if ({eql, cont} !== {1'b1, exp_cont[0]}) begin
            $display("FAIL burst_ev0 got=%b exp=11", {eql, cont});
            bad++;
        end
        tick(); irq = 1'b0; ack = 1'b1;               // c3
        tick(); ack = 1'b0;                           // c4, HOLD
        for (int e = 1; e < 3; e++) begin
            wait_eql(1'b1, n, ok);
            total++;
            if (!ok || (n - 1) < 2) begin
                $display("FAIL burst_gap%0d got=%0d exp>=2", e, n - 1);
                bad++;
            end
            total++;
            if (cont !== exp_cont[e]) begin
                $display("FAIL burst_cont%0d got=%b exp=%b", e, cont, exp_cont[e]);
                bad++;
            end
            tick(); ack = 1'b1;
            tick(); ack = 1'b0;
        end
        total++;
        if ({served, pend} !== {8'd4, 3'd0}) begin
            $display("FAIL burst_counts got=%0d/%0d exp=4/0", served, pend);
            bad++;
        end
        tick(); tick(); tick();
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        irq = 1'b1; tick(); irq = 1'b0;
        wait_eql(1'b1, n, ok);                        // c2
        wait_eql(1'b0, n, ok);
        total++;
        if (!ok || n != 15) begin
            $display("FAIL tmo_high_cycles got=%0d exp=15", n);
            bad++;
        end
        total++;
        if ({tmo, pend} !== {1'b1, 3'd1}) begin
            $display("FAIL tmo_flag got=%b/%0d exp=1/1", tmo, pend);
            bad++;
        end
        wait_eql(1'b1, n, ok);
        total++;
        if (!ok || n != 2) begin
            $display("FAIL tmo_retry_gap got=%0d exp=2", n);
            bad++;
        end
        clr = 1'b1; tick(); clr = 1'b0;
        total++;
        if (tmo !== 1'b0) begin
            $display("FAIL tmo_clear got=%b exp=0", tmo);
            bad++;
        end
        ack = 1'b1; tick(); ack = 1'b0;
        tick(); tick(); tick();
        total++;
        if ({served, pend, busy} !== {8'd5, 3'd0, 1'b0}) begin
            $display("FAIL tmo_drain got=%0d/%0d/%b exp=5/0/0", served, pend, busy);
            bad++;
        end
    endtask

    task automatic test_overflow();
        int n;
        bit ok;
        irq = 1'b1;
        repeat (8) tick();
        irq = 1'b0;
        total++;
        if ({pend, ovf} !== {3'd7, 1'b1}) begin
            $display("FAIL ovf_sat got=%0d/%b exp=7/1", pend, ovf);
            bad++;
        end
        clr = 1'b1; tick(); clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            $display("FAIL ovf_clear got=%b exp=0", ovf);
            bad++;
        end
        wait_eql(1'b0, n, ok);
        wait_eql(1'b1, n, ok);
        total++;
        if (!ok) begin
            $display("FAIL ovf_wait_eql got=timeout exp=eql");
            bad++;
        end
        ack = 1'b1; irq = 1'b1;
        tick();
        ack = 1'b0; irq = 1'b0;
        total++;
        if ({pend, ovf, served, eql} !== {3'd7, 1'b0, 8'd6, 1'b1}) begin
            $display("FAIL ovf_collision got=%0d/%b/%0d/%b exp=7/0/6/1", pend, ovf, served, eql);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        irq = 1'b1; tick(); tick(); tick(); irq = 1'b0;  // c3
        total++;
        if ({pend, eql} !== {3'd3, 1'b1}) begin
            $display("FAIL rstmid_pre got=%0d/%b exp=3/1", pend, eql);
            bad++;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({eql, cont, busy, ovf, tmo, pend, served} !== 16'h0) begin
            $display("FAIL rstmid_async got=%h exp=0000", {eql, cont, busy, ovf, tmo, pend, served});
            bad++;
        end
        tick(); tick(); rst_n = 1'b1;
        tick(); tick(); tick();
        total++;
        if ({eql, busy} !== 2'b00) begin
            $display("FAIL rstmid_after got=%b exp=00", {eql, busy});
            bad++;
        end
    endtask

    task automatic test_wrap();
        int n;
        bit ok;
        int stalls = 0;
        for (int i = 0; i < 256; i++) begin
            irq = 1'b1; tick(); irq = 1'b0;
            wait_eql(1'b1, n, ok);
            if (!ok) stalls++;
            ack = 1'b1; tick(); ack = 1'b0;
            for (int k = 0; k < 10 && busy !== 1'b0; k++) tick();
            if (i == 254) begin
                total++;
                if (served !== 8'd255) begin
                    $display("FAIL wrap_255 got=%0d exp=255", served);
                    bad++;
                end
            end
        end
        total++;
        if (stalls != 0) begin
            $display("FAIL wrap_stalls got=%0d exp=0", stalls);
            bad++;
        end
        total++;
        if (served !== 8'd0) begin
            $display("FAIL wrap_zero got=%0d exp=0", served);
            bad++;
        end
    endtask

    task automatic test_tie();
        int n;
        bit ok;
        irq = 1'b1; tick(); irq = 1'b0;
        wait_eql(1'b1, n, ok);
        repeat (14) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        total++;
        if ({eql, tmo, served, pend} !== {1'b1, 1'b0, 8'd1, 3'd0}) begin
            $display("FAIL tie_ack_wins got=%b/%b/%0d/%0d exp=1/0/1/0", eql, tmo, served, pend);
            bad++;
        end
        tick(); tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0; tick();
        total++;
        if ({served, busy} !== {8'd1, 1'b0}) begin
            $display("FAIL idle_ack_ignored got=%0d/%b exp=1/0", served, busy);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_wrap();
        test_tie();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
